// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial WIDTH-bit adder. One onebitFullAdder cell is fed one operand bit
//   pair per cycle, LSB first. The carry is held in a register between cycles,
//   and the sum bits are collected into a result register.
//
//   Ports:
//     clk    in   1      rising-edge clock
//     rst_n  in   1      asynchronous active-low reset
//     start  in   1      request an add (sampled only in IDLE)
//     a, b   in   WIDTH  operands (sampled on the accepting edge)
//     cin    in   1      carry-in (sampled on the accepting edge)
//     busy   out  1      high while bits are being shifted through the cell
//     done   out  1      one-cycle pulse; sum/cout/ovf are valid
//     sum    out  WIDTH  result register
//     cout   out  1      final carry-out
//     ovf    out  1      signed overflow
//
//   Optional feature macro: SERIAL_ADDER_OVF_EN
//     defined   : ovf = (carry into MSB) ^ (carry out of MSB), registered
//     undefined : ovf tied to 0, and no overflow register is built
//
//   state | meaning
//   ------+----------------------------------------------
//   IDLE  | waiting for start; results held
//   SHIFT | one bit pair per cycle through the adder cell
//   DONE  | results valid, done asserted for one cycle
// -----------------------------------------------------------------------------

module onebitFullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic fa_sum;
  logic fa_cout;

  onebitFullAdder u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q, ovf_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        // Shift right and drop the new sum bit into the MSB. After WIDTH
        // cycles the LSB-first bits are in their natural positions.
        res_d            = res_q >> 1;
        res_d[WIDTH-1]   = fa_sum;
        carry_d          = fa_cout;
        cnt_d            = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
`ifdef SERIAL_ADDER_OVF_EN
          // On the final bit, carry_q is the carry into the MSB.
          ovf_d   = carry_q ^ fa_cout;
`endif
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy = (state_q == S_SHIFT);
  assign done = (state_q == S_DONE);
  assign sum  = res_q;
  assign cout = carry_q;

`ifdef SERIAL_ADDER_OVF_EN
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_checks = 0;
  int n_pass   = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: plain integer arithmetic on the operands.
  function automatic int ref_sum(input int av, input int bv, input int cv);
    return (av + bv + cv) % (1 << W);
  endfunction

  function automatic int ref_cout(input int av, input int bv, input int cv);
    return ((av + bv + cv) >> W) & 1;
  endfunction

  function automatic int ref_ovf(input int av, input int bv, input int cv);
`ifdef SERIAL_ADDER_OVF_EN
    int half, sa, sb, s;
    half = 1 << (W - 1);
    sa   = (av >= half) ? av - 2 * half : av;
    sb   = (bv >= half) ? bv - 2 * half : bv;
    s    = sa + sb + cv;
    return (s > half - 1 || s < -half) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  task automatic do_add(input int av, input int bv, input int cv, input string tag);
    int lat;
    lat = 0;
    @(negedge clk);
    a = W'(av); b = W'(bv); cin = cv[0]; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    for (int k = 1; k <= 3 * W; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    check({tag, "_lat"}, 32'(lat), 32'(W));
    if (lat != 0) begin
      check({tag, "_sum"},  32'(sum),  32'(ref_sum(av, bv, cv)));
      check({tag, "_cout"}, 32'(cout), 32'(ref_cout(av, bv, cv)));
      check({tag, "_ovf"},  32'(ovf),  32'(ref_ovf(av, bv, cv)));
      check({tag, "_busy_off"}, 32'(busy), 32'd0);
    end
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int busy_cnt, done_cnt, got_sum, prev, pulses;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum",  32'(sum),  32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf",  32'(ovf),  32'd0);
    @(negedge clk); rst_n = 1'b1;

    do_add(4'b0101, 4'b0011, 0, "t1");
    do_add(4'b1111, 4'b0001, 0, "t2");
    do_add(4'b1111, 4'b1111, 1, "t3");

    // Results hold in IDLE
    repeat (3) @(posedge clk);
    #1;
    check("hold_sum",  32'(sum),  32'hF);
    check("hold_cout", 32'(cout), 32'd1);

    // start is ignored during SHIFT and DONE
    @(negedge clk);
    a = 4'b0001; b = 4'b0001; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_cnt = busy ? 1 : 0; done_cnt = 0; got_sum = -1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        got_sum = int'(sum);
      end
      start = (c == 2) || done;
      a     = ((c == 2) || done) ? 4'hF : 4'h1;
    end
    start = 1'b0;
    check("ign_busy_cycles", 32'(busy_cnt), 32'd4);
    check("ign_done_count",  32'(done_cnt), 32'd1);
    check("ign_sum",         32'(got_sum),  32'd2);

    // Reset mid-SHIFT
    @(negedge clk);
    a = 4'b0110; b = 4'b0110; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_sum",  32'(sum),  32'd0);
    check("mrst_cout", 32'(cout), 32'd0);
    check("mrst_ovf",  32'(ovf),  32'd0);
    done_cnt = 0; busy_cnt = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
      if (busy) busy_cnt++;
    end
    check("mrst_no_done", 32'(done_cnt), 32'd0);
    check("mrst_idle",    32'(busy_cnt), 32'd0);
    do_add(4'b0110, 4'b0110, 0, "post_rst");

    // Continuous start: one add every WIDTH+2 cycles
    @(negedge clk);
    a = 4'b0010; b = 4'b0011; cin = 1'b0; start = 1'b1;
    prev = 0; pulses = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        check("cont_sum", 32'(sum), 32'h5);
        if (prev != 0) check("cont_period", 32'(c - prev), 32'(W + 2));
        prev = c;
      end
    end
    start = 1'b0;
    check("cont_pulses", 32'(pulses), 32'd5);
    repeat (2) @(posedge clk);

    // Randomized operands against the reference model
    for (int i = 0; i < 20; i++) begin
      do_add(int'($urandom_range(0, (1 << W) - 1)),
             int'($urandom_range(0, (1 << W) - 1)),
             int'($urandom_range(0, 1)), "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
